// File: rtl/regfile_wb_bypass.sv
// Register file with write-back source/destination selection, syscall read
// override and same-cycle write-through bypass. After reset a clear sequence
// zeroes every register while holding the datapath off.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_CLEAR | zeroing reg[clr_cnt] each edge; writes ignored, reads return 0
// ST_RUN   | normal operation: optional write, bypassed combinational reads
module regfile_wb_bypass #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int LINK_REG = 31,
  parameter int SYS_RA   = 2,
  parameter int SYS_RB   = 4,
  parameter bit ZERO_R0  = 1'b1,
  parameter int PC_INC   = 1
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic              in_we,
  input  logic [1:0]        in_wb_sel,
  input  logic [1:0]        in_dst_sel,
  input  logic              in_syscall,
  input  logic [DATA_W-1:0] in_memdata,
  input  logic [DATA_W-1:0] in_r,
  input  logic [DATA_W-1:0] in_pcout,
  input  logic [ADDR_W-1:0] in_p2,
  input  logic [ADDR_W-1:0] in_p4,
  input  logic [ADDR_W-1:0] in_ra,
  input  logic [ADDR_W-1:0] in_rb,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic              out_busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt;
  logic [DATA_W-1:0] regs [DEPTH];

  logic [DATA_W-1:0] w;
  logic [ADDR_W-1:0] rw;
  logic [ADDR_W-1:0] ra_sel;
  logic [ADDR_W-1:0] rb_sel;
  logic              wr_valid;

  // State register; reset always restarts the clear sequence.
  always_ff @(posedge in_clk) begin
    if (in_rst) state_q <= ST_CLEAR;
    else        state_q <= state_d;
  end

  // Next state: leave CLEAR on the edge that clears the last register.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CLEAR: if (clr_cnt == '1) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // Clear index counter, restarted by every reset.
  always_ff @(posedge in_clk) begin
    if (in_rst)                  clr_cnt <= '0;
    else if (state_q == ST_CLEAR) clr_cnt <= clr_cnt + 1'b1;
  end

  // Write-back data select; the link value wraps at DATA_W bits.
  always_comb begin
    w = in_r;
    case (in_wb_sel)
      2'b00:   w = in_memdata;
      2'b10:   w = in_pcout + DATA_W'(PC_INC);
      default: w = in_r;
    endcase
  end

  // Write-back destination select.
  always_comb begin
    rw = ADDR_W'(LINK_REG);
    case (in_dst_sel)
      2'b00:   rw = in_p2;
      2'b01:   rw = in_p4;
      default: rw = ADDR_W'(LINK_REG);
    endcase
  end

  // Read index override during syscall and the effective write qualifier.
  always_comb begin
    ra_sel   = in_syscall ? ADDR_W'(SYS_RA) : in_ra;
    rb_sel   = in_syscall ? ADDR_W'(SYS_RB) : in_rb;
    wr_valid = (state_q == ST_RUN) && in_we && !(ZERO_R0 && (rw == '0));
  end

  // Storage: one write per edge, either a clear or a datapath write.
  always_ff @(posedge in_clk) begin
    if (!in_rst) begin
      if (state_q == ST_CLEAR) regs[clr_cnt] <= '0;
      else if (wr_valid)       regs[rw] <= w;
    end
  end

  // Read port A: hidden during clear, bypass wins over stored value.
  always_comb begin
    out_a = regs[ra_sel];
    if (state_q != ST_RUN)                out_a = '0;
    else if (wr_valid && (rw == ra_sel))  out_a = w;
    else if (ZERO_R0 && (ra_sel == '0))   out_a = '0;
  end

  // Read port B: same rules as port A.
  always_comb begin
    out_b = regs[rb_sel];
    if (state_q != ST_RUN)                out_b = '0;
    else if (wr_valid && (rw == rb_sel))  out_b = w;
    else if (ZERO_R0 && (rb_sel == '0))   out_b = '0;
  end

  assign out_busy = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_regfile_wb_bypass.sv
// Bench for regfile_wb_bypass: directed scenarios followed by random traffic,
// all compared against a behavioural register-file model.
module tb_regfile_wb_bypass;

  logic        in_clk;
  logic        in_rst;
  logic        in_we;
  logic [1:0]  in_wb_sel;
  logic [1:0]  in_dst_sel;
  logic        in_syscall;
  logic [31:0] in_memdata;
  logic [31:0] in_r;
  logic [31:0] in_pcout;
  logic [4:0]  in_p2, in_p4, in_ra, in_rb;
  logic [31:0] out_a, out_b;
  logic        out_busy;

  int checks   = 0;
  int failures = 0;

  // Model: register contents plus number of clear cycles still outstanding.
  logic [31:0] m_regs [32];
  int          m_clear_left = 0;

  regfile_wb_bypass dut (
    .in_clk(in_clk), .in_rst(in_rst), .in_we(in_we), .in_wb_sel(in_wb_sel),
    .in_dst_sel(in_dst_sel), .in_syscall(in_syscall), .in_memdata(in_memdata),
    .in_r(in_r), .in_pcout(in_pcout), .in_p2(in_p2), .in_p4(in_p4),
    .in_ra(in_ra), .in_rb(in_rb), .out_a(out_a), .out_b(out_b),
    .out_busy(out_busy)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  function automatic logic [31:0] m_wdata();
    case (in_wb_sel)
      2'd0:    return in_memdata;
      2'd2:    return in_pcout + 32'd1;
      default: return in_r;
    endcase
  endfunction

  function automatic logic [4:0] m_wdst();
    if (in_dst_sel == 2'd0) return in_p2;
    if (in_dst_sel == 2'd1) return in_p4;
    return 5'd31;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] idx);
    if (m_clear_left > 0) return 32'd0;
    if (in_we && m_wdst() != 5'd0 && m_wdst() == idx) return m_wdata();
    if (idx == 5'd0) return 32'd0;
    return m_regs[idx];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [4:0] ia, ib;
    ia = in_syscall ? 5'd2 : in_ra;
    ib = in_syscall ? 5'd4 : in_rb;
    check({tag, "_a"}, out_a, m_read(ia));
    check({tag, "_b"}, out_b, m_read(ib));
    check({tag, "_busy"}, {31'd0, out_busy}, {31'd0, m_clear_left > 0});
  endtask

  // One clock edge: advance the model with the inputs held across the edge.
  task automatic tick();
    logic [31:0] wd;
    logic [4:0]  wi;
    wd = m_wdata();
    wi = m_wdst();
    @(posedge in_clk);
    #1;
    if (in_rst) m_clear_left = 32;
    else if (m_clear_left > 0) begin
      m_clear_left--;
      if (m_clear_left == 0) for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    end else if (in_we && wi != 5'd0) m_regs[wi] = wd;
  endtask

  task automatic idle();
    in_rst = 0; in_we = 0; in_wb_sel = 0; in_dst_sel = 0; in_syscall = 0;
    in_memdata = 0; in_r = 0; in_pcout = 0; in_p2 = 0; in_p4 = 0; in_ra = 0; in_rb = 0;
  endtask

  task automatic write_reg(input logic [4:0] idx, input logic [31:0] val);
    in_we = 1; in_wb_sel = 2'd1; in_r = val; in_dst_sel = 2'd0; in_p2 = idx;
    #1 check_all("wr");
    tick();
    in_we = 0;
  endtask

  task automatic reset_and_clear();
    in_rst = 1;
    tick();
    in_rst = 0;
    for (int i = 0; i < 32; i++) begin
      #1 check("clr_busy_hi", {31'd0, out_busy}, 32'd1);
      tick();
    end
    #1 check("clr_busy_lo", {31'd0, out_busy}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    idle();
    @(posedge in_clk);
    #1;
    reset_and_clear();

    // 1: preload r7, reset, 32 busy cycles, then r7 reads 0
    write_reg(5'd7, 32'hDEAD);
    in_ra = 5'd7;
    #1 check("t1_pre", out_a, 32'hDEAD);
    reset_and_clear();
    in_ra = 5'd7;
    #1 check("t1_r7_zero", out_a, 32'd0);

    // 2: bypass then stored
    in_we = 1; in_wb_sel = 2'd1; in_r = 32'h1234; in_dst_sel = 2'd0; in_p2 = 5'd5; in_ra = 5'd5;
    #1 check("t2_bypass", out_a, 32'h1234);
    check_all("t2");
    tick();
    in_we = 0;
    #1 check("t2_stored", out_a, 32'h1234);

    // 3: link write-back with wrap
    in_we = 1; in_wb_sel = 2'd2; in_dst_sel = 2'd2; in_pcout = 32'hFFFF_FFFF; in_ra = 5'd31;
    #1 check("t3_wrap_byp", out_a, 32'd0);
    tick();
    in_we = 0;
    #1 check("t3_wrap", out_a, 32'd0);
    in_we = 1; in_pcout = 32'h40;
    #1 check("t3_link_byp", out_a, 32'h41);
    tick();
    in_we = 0;
    #1 check("t3_link", out_a, 32'h41);

    // 4: r0 is hardwired zero
    in_we = 1; in_wb_sel = 2'd1; in_r = 32'h55; in_dst_sel = 2'd0; in_p2 = 5'd0; in_ra = 5'd0;
    #1 check("t4_r0_same", out_a, 32'd0);
    tick();
    in_we = 0;
    #1 check("t4_r0_after", out_a, 32'd0);

    // 5: syscall read override, including bypass on a forced index
    write_reg(5'd2, 32'h11);
    write_reg(5'd4, 32'h22);
    in_syscall = 1; in_ra = 5'd9; in_rb = 5'd10;
    #1 check("t5_sys_a", out_a, 32'h11);
    check("t5_sys_b", out_b, 32'h22);
    in_we = 1; in_wb_sel = 2'd0; in_memdata = 32'h77; in_dst_sel = 2'd1; in_p4 = 5'd4;
    #1 check("t5_sys_byp_b", out_b, 32'h77);
    check("t5_sys_nobyp_a", out_a, 32'h11);
    in_we = 0; in_syscall = 0;

    // 6: reset at clear cycle 10, write attempts during clear
    in_rst = 1;
    tick();
    in_rst = 0;
    for (int i = 0; i < 10; i++) tick();
    in_rst = 1;
    tick();
    in_rst = 0;
    for (int i = 0; i < 32; i++) begin
      in_we = i[0]; in_wb_sel = 2'd1; in_r = $urandom | 32'h1; in_dst_sel = 2'd0;
      in_p2 = 5'(i); in_ra = 5'(i); in_rb = 5'(31 - i);
      #1 check("t6_busy", {31'd0, out_busy}, 32'd1);
      check("t6_a_hidden", out_a, 32'd0);
      tick();
    end
    idle();
    #1 check("t6_done", {31'd0, out_busy}, 32'd0);
    for (int i = 0; i < 32; i++) begin
      in_ra = 5'(i);
      #1 check("t6_zero", out_a, 32'd0);
    end

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      in_rst     = ($urandom_range(0, 149) == 0);
      in_we      = $urandom_range(0, 1);
      in_wb_sel  = 2'($urandom_range(0, 3));
      in_dst_sel = 2'($urandom_range(0, 3));
      in_syscall = ($urandom_range(0, 7) == 0);
      in_memdata = $urandom;
      in_r       = $urandom;
      in_pcout   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      in_p2      = 5'($urandom_range(0, 31));
      in_p4      = 5'($urandom_range(0, 31));
      in_ra      = ($urandom_range(0, 3) == 0) ? in_p2 : 5'($urandom_range(0, 31));
      in_rb      = ($urandom_range(0, 3) == 0) ? in_ra : 5'($urandom_range(0, 31));
      #1 check_all("rnd");
      tick();
    end

    // Final sweep of stored contents
    idle();
    for (int i = 0; i < 40; i++) tick();
    for (int i = 0; i < 32; i++) begin
      in_ra = 5'(i); in_rb = 5'(31 - i);
      #1 check_all("sweep");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
